// File: rtl/bus_collector.sv
// ---------------------------------------------------------------------------
// bus_collector
//   Merges NUM_INPUTS lanes of single-cycle valid pulses back into one ordered
//   ready/valid stream. Words leave in strict lane order 0,1,..,NUM_INPUTS-1,0,..
//   Each lane has its own FIFO to absorb inter-lane skew. Ordering is
//   head-of-line: if the expected lane is empty, the output waits.
//
// Ports
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   data_in        per-lane data, sampled when valid_in[i]=1
//   valid_in       per-lane write strobes, any mix per cycle
//   data_out       merged word (registered)
//   valid_out      data_out holds a valid word
//   ready_in       consumer accepts when valid_out && ready_in
//   lane_ix_out    source lane of the current data_out
//   lane_full_out  lane FIFO i holds LANE_DEPTH entries
//   overflow_out   sticky flag: at least one word was dropped
//
// Optional feature (macro BUS_COLLECTOR_STATS_EN)
//   word_count_out [31:0]  handshake counter, wraps
//   drop_count_out [15:0]  dropped-word counter, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module bus_collector #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 6,
    parameter int LANE_DEPTH = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_INPUTS-1:0]                  valid_in,
    output logic [DATA_WIDTH-1:0]                  data_out,
    output logic                                   valid_out,
    input  logic                                   ready_in,
    output logic [$clog2(NUM_INPUTS)-1:0]          lane_ix_out,
    output logic [NUM_INPUTS-1:0]                  lane_full_out,
    output logic                                   overflow_out
`ifdef BUS_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                            word_count_out,
    output logic [15:0]                            drop_count_out
`endif
);

    localparam int IXW = $clog2(NUM_INPUTS);
    localparam int PW  = $clog2(LANE_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(LANE_DEPTH);
    localparam logic [IXW-1:0] LAST_IX_C = IXW'(NUM_INPUTS - 1);

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    logic [DATA_WIDTH-1:0] mem_r     [NUM_INPUTS][LANE_DEPTH];
    logic [PW:0]           wr_ptr_r  [NUM_INPUTS];
    logic [PW:0]           rd_ptr_r  [NUM_INPUTS];
    logic [PW:0]           cnt_s     [NUM_INPUTS];
    logic [PW:0]           cnt_nxt_s [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] full_s;
    logic [NUM_INPUTS-1:0] pop_s;
    logic [NUM_INPUTS-1:0] push_s;
    logic [NUM_INPUTS-1:0] drop_s;
    logic [IXW-1:0]        expect_ix_r;
    logic [IXW-1:0]        expect_nxt_s;
    logic                  head_valid_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  load_en_s;

    // Per-lane occupancy and the head word of the lane the output is waiting on.
    always_comb begin
        head_valid_s = 1'b0;
        head_data_s  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_s[i]     = wr_ptr_r[i] - rd_ptr_r[i];
            head_valid_s = (expect_ix_r == IXW'(i)) ? (cnt_s[i] != '0) : head_valid_s;
            head_data_s  = (expect_ix_r == IXW'(i)) ? mem_r[i][rd_ptr_r[i][PW-1:0]] : head_data_s;
        end
    end

    assign load_en_s    = (!valid_out || ready_in) && head_valid_s;
    assign expect_nxt_s = (expect_ix_r == LAST_IX_C) ? '0 : (expect_ix_r + IXW'(1));

    // Push/pop decisions; a full lane still accepts a write when it pops in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            full_s[i]    = (cnt_s[i] == DEPTH_C);
            pop_s[i]     = load_en_s && (expect_ix_r == IXW'(i));
            push_s[i]    = valid_in[i] && (!full_s[i] || pop_s[i]);
            drop_s[i]    = valid_in[i] && full_s[i] && !pop_s[i];
            cnt_nxt_s[i] = cnt_s[i] + (PW+1)'(push_s[i]) - (PW+1)'(pop_s[i]);
        end
    end

    // Lane storage; contents are only read once written, so no reset is needed.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i][PW-1:0]] <= data_in[i];
            end else begin
                mem_r[i][wr_ptr_r[i][PW-1:0]] <= mem_r[i][wr_ptr_r[i][PW-1:0]];
            end
        end
    end

    // Lane pointers, full flags and the sticky overflow flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
            lane_full_out <= '0;
            overflow_out  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr_r[i]      <= wr_ptr_r[i] + (PW+1)'(push_s[i]);
                rd_ptr_r[i]      <= rd_ptr_r[i] + (PW+1)'(pop_s[i]);
                // Registered from the next count so the flag lines up with occupancy.
                lane_full_out[i] <= (cnt_nxt_s[i] == DEPTH_C);
            end
            overflow_out <= overflow_out | (|drop_s);
        end
    end

    // Registered output stage and round-robin lane pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            lane_ix_out <= '0;
            expect_ix_r <= '0;
        end else if (load_en_s) begin
            data_out    <= head_data_s;
            valid_out   <= 1'b1;
            lane_ix_out <= expect_ix_r;
            expect_ix_r <= expect_nxt_s;
        end else if (ready_in) begin
            // Word consumed with nothing to replace it (or already idle).
            valid_out   <= 1'b0;
        end else begin
            // Stall: hold everything.
            valid_out   <= valid_out;
        end
    end

`ifdef BUS_COLLECTOR_STATS_EN
    logic [16:0] drop_sum_s;

    // Add this cycle's dropped words to the running total.
    always_comb begin
        drop_sum_s = {1'b0, drop_count_out};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            drop_sum_s = drop_sum_s + 17'(drop_s[i]);
        end
    end

    // Statistics counters: handshakes wrap, drops saturate.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            word_count_out <= 32'd0;
            drop_count_out <= 16'd0;
        end else begin
            word_count_out <= word_count_out + 32'(valid_out && ready_in);
            drop_count_out <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_bus_collector.sv
module tb_bus_collector;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic             rst_n_in;
    // Main instance: 4 lanes
    logic [3:0][5:0]  data_in;
    logic [3:0]       valid_in;
    logic             ready_in;
    logic [5:0]       data_out;
    logic             valid_out;
    logic [1:0]       lane_ix_out;
    logic [3:0]       lane_full_out;
    logic             overflow_out;
    // Second instance: 3 lanes
    logic [2:0][5:0]  d3;
    logic [2:0]       v3;
    logic             r3;
    logic [5:0]       do3;
    logic             vo3;
    logic [1:0]       ix3;
    logic [2:0]       lf3;
    logic             of3;
`ifdef BUS_COLLECTOR_STATS_EN
    logic [31:0]      word_count;
    logic [15:0]      drop_count;
    logic [31:0]      wc3;
    logic [15:0]      dc3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bus_collector #(.NUM_INPUTS(4), .DATA_WIDTH(6), .LANE_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .lane_ix_out(lane_ix_out), .lane_full_out(lane_full_out),
        .overflow_out(overflow_out)
`ifdef BUS_COLLECTOR_STATS_EN
        , .word_count_out(word_count), .drop_count_out(drop_count)
`endif
    );

    bus_collector #(.NUM_INPUTS(3), .DATA_WIDTH(6), .LANE_DEPTH(4)) dut3 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .data_in(d3), .valid_in(v3),
        .data_out(do3), .valid_out(vo3), .ready_in(r3),
        .lane_ix_out(ix3), .lane_full_out(lf3),
        .overflow_out(of3)
`ifdef BUS_COLLECTOR_STATS_EN
        , .word_count_out(wc3), .drop_count_out(dc3)
`endif
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        data_in  = '0; valid_in = '0; ready_in = 1'b0;
        d3 = '0; v3 = '0; r3 = 1'b0;
        rst_n_in = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (data_out !== 6'h00) begin n_fail++; $display("FAIL reset_data got %0h want 0", data_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid_out); end
        n_checks++; if (lane_ix_out !== 2'd0) begin n_fail++; $display("FAIL reset_ix got %0d want 0", lane_ix_out); end
        n_checks++; if (lane_full_out !== 4'b0000) begin n_fail++; $display("FAIL reset_full got %b want 0000", lane_full_out); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow_out); end
`ifdef BUS_COLLECTOR_STATS_EN
        n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset_wc got %0d want 0", word_count); end
`endif
    endtask

    // Lanes 0..3 on successive cycles; each word appears one edge after its write.
    task automatic test_in_order();
        apply_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_in = '0; valid_in = '0;
            if (k < 4) begin valid_in[k] = 1'b1; data_in[k] = 6'(k + 1); end
            step();
            if (k >= 1 && k <= 4) begin
                n_checks++; if (valid_out !== 1'b1 || data_out !== 6'(k) || lane_ix_out !== 2'(k - 1)) begin
                    n_fail++; $display("FAIL in_order k=%0d got v=%0b d=%0h ix=%0d want v=1 d=%0h ix=%0d", k, valid_out, data_out, lane_ix_out, k, k - 1);
                end
            end else begin
                n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL in_order_idle k=%0d got v=%0b want 0", k, valid_out); end
            end
        end
    endtask

    // Lane 1 arrives first; output must wait for lane 0.
    task automatic test_skew();
        apply_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            data_in = '0; valid_in = '0;
            if (k == 0) begin valid_in[1] = 1'b1; data_in[1] = 6'h2A; end
            if (k == 3) begin valid_in[0] = 1'b1; data_in[0] = 6'h15; end
            step();
            if (k == 4) begin
                n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h15 || lane_ix_out !== 2'd0) begin
                    n_fail++; $display("FAIL skew_first got v=%0b d=%0h ix=%0d want v=1 d=15 ix=0", valid_out, data_out, lane_ix_out);
                end
            end else if (k == 5) begin
                n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h2A || lane_ix_out !== 2'd1) begin
                    n_fail++; $display("FAIL skew_second got v=%0b d=%0h ix=%0d want v=1 d=2a ix=1", valid_out, data_out, lane_ix_out);
                end
            end else begin
                n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL skew_wait k=%0d got v=%0b want 0", k, valid_out); end
            end
        end
    endtask

    // All lanes write at once, consumer stalls 5 cycles, then drains back-to-back.
    task automatic test_backpressure();
        logic       exp_v;
        logic [5:0] exp_d;
        logic [1:0] exp_ix;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            ready_in = (k >= 6);
            valid_in = (k == 0) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < 4; i++) data_in[i] = 6'(8'h10 + i);
            step();
            exp_v  = (k >= 1 && k <= 8);
            exp_d  = (k <= 5) ? 6'h10 : 6'(16 + k - 5);
            exp_ix = (k <= 5) ? 2'd0 : 2'(k - 5);
            n_checks++;
            if (valid_out !== exp_v || (exp_v && (data_out !== exp_d || lane_ix_out !== exp_ix))) begin
                n_fail++; $display("FAIL backpressure k=%0d got v=%0b d=%0h ix=%0d want v=%0b d=%0h ix=%0d", k, valid_out, data_out, lane_ix_out, exp_v, exp_d, exp_ix);
            end
        end
    endtask

    // Five writes to a 4-deep lane 2 with nothing draining; 5th is dropped.
    task automatic test_overflow();
        int         n;
        logic [5:0] exp_d;
        apply_reset();
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data_in = '0; valid_in = 4'b0100; data_in[2] = 6'(8'h20 + k);
            step();
            n_checks++; if (lane_full_out !== ((k >= 3) ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL ovf_full k=%0d got %b", k, lane_full_out);
            end
            n_checks++; if (overflow_out !== (k >= 4)) begin
                n_fail++; $display("FAIL ovf_flag k=%0d got %0b want %0b", k, overflow_out, (k >= 4));
            end
        end
`ifdef BUS_COLLECTOR_STATS_EN
        n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_dropcnt got %0d want 1", drop_count); end
`endif
        // Feed lanes 0,1,3 so lane 2 fully drains; only 0x20..0x23 may appear.
        ready_in = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            data_in = '0;
            valid_in = (c < 4) ? 4'b1011 : 4'b0000;
            data_in[0] = 6'(c); data_in[1] = 6'(8 + c); data_in[3] = 6'(24 + c);
            step();
            if (valid_out) begin
                case (n % 4)
                    0: exp_d = 6'(n / 4);
                    1: exp_d = 6'(8 + n / 4);
                    2: exp_d = 6'(32 + n / 4);
                    default: exp_d = 6'(24 + n / 4);
                endcase
                n_checks++; if (n >= 16 || data_out !== exp_d || lane_ix_out !== 2'(n % 4)) begin
                    n_fail++; $display("FAIL ovf_drain n=%0d got d=%0h ix=%0d want d=%0h ix=%0d", n, data_out, lane_ix_out, exp_d, n % 4);
                end
                n++;
            end
        end
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL ovf_count got %0d words want 16", n); end
        n_checks++; if (overflow_out !== 1'b1 || lane_full_out !== 4'b0000) begin
            n_fail++; $display("FAIL ovf_sticky got ovf=%0b full=%b want ovf=1 full=0000", overflow_out, lane_full_out);
        end
    endtask

    // Three-lane instance: seven round-robin words wrap the lane index.
    task automatic test_wrap();
        int n;
        apply_reset();
        r3 = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            d3 = '0; v3 = '0;
            if (c < 7) begin v3[c % 3] = 1'b1; d3[c % 3] = 6'(8'h30 + c); end
            step();
            if (vo3) begin
                n_checks++; if (n >= 7 || ix3 !== 2'(n % 3) || do3 !== 6'(8'h30 + n)) begin
                    n_fail++; $display("FAIL wrap n=%0d got ix=%0d d=%0h want ix=%0d d=%0h", n, ix3, do3, n % 3, 8'h30 + n);
                end
                n++;
            end
        end
        n_checks++; if (n != 7) begin n_fail++; $display("FAIL wrap_count got %0d want 7", n); end
        n_checks++; if (of3 !== 1'b0 || lf3 !== 3'b000) begin n_fail++; $display("FAIL wrap_flags got ovf=%0b full=%b", of3, lf3); end
    endtask

    // Reset while words are in flight; afterwards lane 0 leads again.
    task automatic test_reset_mid();
        int n;
        apply_reset();
        ready_in = 1'b1;
        valid_in = 4'b1111;
        data_in[0] = 6'h05; data_in[1] = 6'h06; data_in[2] = 6'h07; data_in[3] = 6'h08;
        step();
        valid_in = '0;
        step();
        step();
        n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h06) begin
            n_fail++; $display("FAIL mid_pre got v=%0b d=%0h want v=1 d=06", valid_out, data_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0 || data_out !== 6'h00 || lane_ix_out !== 2'd0) begin
            n_fail++; $display("FAIL mid_async got v=%0b d=%0h ix=%0d want 0", valid_out, data_out, lane_ix_out);
        end
`ifdef BUS_COLLECTOR_STATS_EN
        n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL mid_wc got %0d want 0", word_count); end
`endif
        step();
        rst_n_in = 1'b1;
        data_in = '0; valid_in = 4'b0011; data_in[0] = 6'h1C; data_in[1] = 6'h2B;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            valid_in = '0;
            if (valid_out) begin
                n_checks++; if (n >= 2 || data_out !== ((n == 0) ? 6'h1C : 6'h2B) || lane_ix_out !== 2'(n)) begin
                    n_fail++; $display("FAIL mid_after n=%0d got d=%0h ix=%0d", n, data_out, lane_ix_out);
                end
                n++;
            end
        end
        n_checks++; if (n != 2) begin n_fail++; $display("FAIL mid_count got %0d want 2", n); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_skew();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
